// File: rtl/coin_credit_collector_pkg.sv
// Shared definitions for the vending purchase path: state encoding, coin codes,
// coin values and money width.
package vend_pkg;

  localparam int MONEY_W        = 4;
  localparam int MAX_CREDIT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    OFFER   = 2'b10,
    REFUND  = 2'b11
  } state_e;

  localparam logic [1:0] COIN_1       = 2'b00;
  localparam logic [1:0] COIN_2       = 2'b01;
  localparam logic [1:0] COIN_5       = 2'b10;
  localparam logic [1:0] COIN_INVALID = 2'b11;

  // Returns the 5-bit money value of a coin code; the invalid code is worth 0.
  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] value;
    case (code)
      COIN_1:  value = 5'd1;
      COIN_2:  value = 5'd2;
      COIN_5:  value = 5'd5;
      default: value = 5'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coin_credit_collector_if.sv
// Valid/ready offer channel carrying the collected credit to the customer stage.
interface coin_credit_collector_if;
  import vend_pkg::*;

  logic               offer_valid;
  logic [MONEY_W-1:0] offer_money;
  logic               offer_ready;

  modport master (output offer_valid, output offer_money, input offer_ready);
  modport slave  (input offer_valid, input offer_money, output offer_ready);
endinterface

// File: rtl/coin_credit_collector_inactivity_timer.sv
// Inactivity counter: counts enabled cycles since the last clear and flags the
// final cycle of the timeout window.
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Counter register: clear wins, then saturating increment while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Independent of clear so the owner may fold expiry into its clear decision.
  assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/coin_credit_collector.sv
// Coin credit collector: accumulates coin credit, offers it to the customer stage
// over a valid/ready channel, or refunds it on cancel, timeout or maintenance mode.
module coin_credit_collector
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10,
  parameter int MAX_CREDIT     = MAX_CREDIT_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode,
  input  logic                           coin_valid,
  input  logic [1:0]                     coin_type,
  input  logic                           buy,
  input  logic                           cancel,
  coin_credit_collector_if.master        offer,
  output logic [MONEY_W-1:0]             credit,
  output logic                           coin_reject,
  output logic                           refund_valid,
  output logic [MONEY_W-1:0]             refund_amount,
  output logic                           busy
);

  state_e             state_r, state_next_s;
  logic [MONEY_W-1:0] credit_r, credit_next_s;
  logic [MONEY_W-1:0] offer_money_r, refund_amount_r;
  logic               offer_valid_r, coin_reject_r, refund_valid_r, busy_r;
  logic [4:0]         sum_s;
  logic               coin_ok_s, accept_s, expired_s, timer_clear_s, timer_en_s;

  assign timer_en_s    = (state_r == COLLECT);
  assign timer_clear_s = accept_s || (state_r != COLLECT);

  inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  // Coin eligibility: 5-bit sum so the ceiling compare can never wrap.
  always_comb begin
    sum_s     = {1'b0, credit_r} + coin_value(coin_type);
    coin_ok_s = coin_valid && (coin_type != COIN_INVALID) && mode &&
                !buy && !cancel && (sum_s <= 5'(MAX_CREDIT));
  end

  // Next-state and credit datapath.
  always_comb begin
    state_next_s  = state_r;
    credit_next_s = credit_r;
    accept_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (coin_ok_s) begin
          accept_s      = 1'b1;
          state_next_s  = COLLECT;
          credit_next_s = sum_s[MONEY_W-1:0];
        end else begin
          state_next_s  = IDLE;
        end
      end
      COLLECT: begin
        if (!mode || cancel) begin
          state_next_s = REFUND;
        end else if (buy) begin
          state_next_s = OFFER;
        end else if (expired_s) begin
          state_next_s = REFUND;
        end else if (coin_ok_s) begin
          accept_s      = 1'b1;
          credit_next_s = sum_s[MONEY_W-1:0];
        end else begin
          state_next_s = COLLECT;
        end
      end
      OFFER: begin
        if (offer_valid_r && offer.offer_ready) begin
          state_next_s  = IDLE;
          credit_next_s = {MONEY_W{1'b0}};
        end else begin
          state_next_s  = OFFER;
        end
      end
      REFUND: begin
        state_next_s  = IDLE;
        credit_next_s = {MONEY_W{1'b0}};
      end
      default: begin
        state_next_s  = IDLE;
        credit_next_s = {MONEY_W{1'b0}};
      end
    endcase
  end

  // State, credit and every output are registered from the next-state view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      credit_r        <= {MONEY_W{1'b0}};
      offer_valid_r   <= 1'b0;
      offer_money_r   <= {MONEY_W{1'b0}};
      coin_reject_r   <= 1'b0;
      refund_valid_r  <= 1'b0;
      refund_amount_r <= {MONEY_W{1'b0}};
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      credit_r        <= credit_next_s;
      offer_valid_r   <= (state_next_s == OFFER);
      offer_money_r   <= (state_next_s == OFFER) ? credit_next_s : {MONEY_W{1'b0}};
      coin_reject_r   <= coin_valid && !accept_s;
      refund_valid_r  <= (state_next_s == REFUND);
      refund_amount_r <= (state_next_s == REFUND) ? credit_next_s : {MONEY_W{1'b0}};
      busy_r          <= (state_next_s != IDLE);
    end
  end

  assign offer.offer_valid = offer_valid_r;
  assign offer.offer_money = offer_money_r;
  assign credit            = credit_r;
  assign coin_reject       = coin_reject_r;
  assign refund_valid      = refund_valid_r;
  assign refund_amount     = refund_amount_r;
  assign busy              = busy_r;

endmodule

// File: tb/tb_coin_credit_collector.sv
// Bench for coin_credit_collector: directed scenarios followed by random traffic,
// every cycle compared against a purchase-level reference model.
module tb_coin_credit_collector;
  import vend_pkg::*;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] credit, refund_amount;
  logic       coin_reject, refund_valid, busy;

  coin_credit_collector_if ofr ();

  coin_credit_collector #(.TIMEOUT_CYCLES(T), .CNT_W(4), .MAX_CREDIT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .coin_valid    (coin_valid),
    .coin_type     (coin_type),
    .buy           (buy),
    .cancel        (cancel),
    .offer         (ofr),
    .credit        (credit),
    .coin_reject   (coin_reject),
    .refund_valid  (refund_valid),
    .refund_amount (refund_amount),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the customer sees, tracked as purchase activities.
  int m_credit, m_quiet;
  bit m_collecting, m_offering, m_refunding;
  bit e_reject;
  int e_refund;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_quiet = 0;
    m_collecting = 0; m_offering = 0; m_refunding = 0;
    e_reject = 0; e_refund = -1;
  endtask

  task automatic model_step();
    int v;
    bit ok;
    v = (coin_type == 2'd0) ? 1 : (coin_type == 2'd1) ? 2 : (coin_type == 2'd2) ? 5 : 0;
    ok = coin_valid && coin_type != 2'd3 && mode && !buy && !cancel && (m_credit + v <= 15);
    e_reject = coin_valid;
    e_refund = -1;
    if (m_refunding) begin
      m_refunding = 0; m_credit = 0;
    end else if (m_offering) begin
      if (ofr.offer_ready) begin
        m_offering = 0; m_credit = 0;
      end
    end else if (m_collecting) begin
      if (!mode || cancel || (!buy && m_quiet + 1 == T)) begin
        m_collecting = 0; m_refunding = 1; e_refund = m_credit;
      end else if (buy) begin
        m_collecting = 0; m_offering = 1;
      end else if (ok) begin
        m_credit += v; m_quiet = 0; e_reject = 0;
      end else begin
        m_quiet++;
      end
    end else if (ok) begin
      m_collecting = 1; m_credit = v; m_quiet = 0; e_reject = 0;
    end
  endtask

  task automatic check_all();
    check("credit", 8'(credit), 8'(m_credit));
    check("offer_valid", 8'(ofr.offer_valid), 8'(m_offering));
    check("offer_money", 8'(ofr.offer_money), m_offering ? 8'(m_credit) : 8'd0);
    check("coin_reject", 8'(coin_reject), 8'(e_reject));
    check("refund_valid", 8'(refund_valid), 8'(e_refund >= 0));
    check("refund_amount", 8'(refund_amount), (e_refund >= 0) ? 8'(e_refund) : 8'd0);
    check("busy", 8'(busy), 8'(m_collecting || m_offering || m_refunding));
  endtask

  task automatic cycle(input bit cv, input logic [1:0] ct, input bit b, input bit c, input bit rdy);
    coin_valid = cv; coin_type = ct; buy = b; cancel = c; ofr.offer_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, rdy);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_credit"}, 8'(credit), 8'd0);
    check({tag, "_offer_valid"}, 8'(ofr.offer_valid), 8'd0);
    check({tag, "_offer_money"}, 8'(ofr.offer_money), 8'd0);
    check({tag, "_coin_reject"}, 8'(coin_reject), 8'd0);
    check({tag, "_refund_valid"}, 8'(refund_valid), 8'd0);
    check({tag, "_refund_amount"}, 8'(refund_amount), 8'd0);
    check({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  initial begin
    ofr.offer_ready = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Coins 5, 2, 1 then buy with ready held high.
    cycle(1'b1, COIN_5, 1'b0, 1'b0, 1'b1); check("t1_c5", 8'(credit), 8'd5);
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b1); check("t1_c7", 8'(credit), 8'd7);
    cycle(1'b1, COIN_1, 1'b0, 1'b0, 1'b1); check("t1_c8", 8'(credit), 8'd8);
    cycle(1'b0, COIN_1, 1'b1, 1'b0, 1'b1);
    check("t1_offer_valid", 8'(ofr.offer_valid), 8'd1);
    check("t1_offer_money", 8'(ofr.offer_money), 8'd8);
    idle(1'b1);
    check("t1_done_valid", 8'(ofr.offer_valid), 8'd0);
    check("t1_done_credit", 8'(credit), 8'd0);

    // Ceiling: 12 + 5 rejected, 12 + 2 accepted.
    cycle(1'b1, COIN_5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0); check("t2_c12", 8'(credit), 8'd12);
    cycle(1'b1, COIN_5, 1'b0, 1'b0, 1'b0);
    check("t2_reject", 8'(coin_reject), 8'd1);
    check("t2_hold12", 8'(credit), 8'd12);
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0); check("t2_c14", 8'(credit), 8'd14);
    cycle(1'b0, COIN_1, 1'b0, 1'b1, 1'b0); check("t2_refund", 8'(refund_amount), 8'd14);
    idle(1'b0);

    // Timeout: credit 3, refund exactly T cycles after the last coin.
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= T; k++) begin
      idle(1'b0);
      check("t3_refund_valid", 8'(refund_valid), (k == T) ? 8'd1 : 8'd0);
    end
    check("t3_refund_amount", 8'(refund_amount), 8'd3);
    idle(1'b0); check("t3_credit", 8'(credit), 8'd0);

    // Coin together with cancel.
    cycle(1'b1, COIN_5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_1, 1'b0, 1'b1, 1'b0);
    check("t4_reject", 8'(coin_reject), 8'd1);
    check("t4_refund", 8'(refund_amount), 8'd6);
    idle(1'b0);

    // Offer of 4 stalled for 5 cycles with a coin and a cancel injected.
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, COIN_1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(i == 1, COIN_1, 1'b0, i == 3, 1'b0);
      check("t5_money", 8'(ofr.offer_money), 8'd4);
      check("t5_no_refund", 8'(refund_valid), 8'd0);
      if (i == 1) check("t5_reject", 8'(coin_reject), 8'd1);
    end
    idle(1'b1); check("t5_handshake", 8'(ofr.offer_valid), 8'd0);

    // Reset in the middle of a collection with credit 9.
    cycle(1'b1, COIN_5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0); check("t6_c9", 8'(credit), 8'd9);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0); check("t6_no_refund", 8'(refund_valid), 8'd0);

    // Coin in maintenance mode.
    mode = 1'b0;
    cycle(1'b1, COIN_2, 1'b0, 1'b0, 1'b0); check("t7_reject", 8'(coin_reject), 8'd1);
    mode = 1'b1;
    idle(1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      mode = ($urandom_range(0, 24) != 0);
      cycle($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coin_credit_collector.md
Name: coin_credit_collector

Overview:
Upstream stage of the customer purchase logic.
- Accepts coin insertions and accumulates a 4-bit credit.
- Hands the credit to the customer stage over a valid/ready offer; the offered amount feeds that stage's costumer_money input.
- On cancel, inactivity timeout, or a switch to maintenance mode, it issues a one-cycle refund of the held credit.

Parameters:
- TIMEOUT_CYCLES, default 1000: idle cycles in COLLECT before an automatic refund; legal range 2 to 2^CNT_W.
- CNT_W, default 10: width of the inactivity counter.
- MAX_CREDIT, default 15: credit ceiling; must be 15 or less (4-bit credit).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  1 = customer mode, 0 = maintenance mode
- coin_valid  in  1  one-cycle coin-insert pulse
- coin_type  in  2  00 = 1 unit, 01 = 2 units, 10 = 5 units, 11 = invalid
- buy  in  1  one-cycle purchase-confirm pulse
- cancel  in  1  one-cycle cancel pulse
- offer_ready  in  1  customer stage accepts the offer
- offer_valid  out  1  offer held
- offer_money  out  4  offered credit; feeds costumer_money
- credit  out  4  current accumulated credit
- coin_reject  out  1  one-cycle pulse, coin returned
- refund_valid  out  1  one-cycle refund pulse
- refund_amount  out  4  refunded value; qualified by refund_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock domain; all outputs are registered.
- Reset (async assert, sync release): state = IDLE; credit, timer, offer_valid, offer_money, coin_reject, refund_valid, refund_amount and busy all clear to 0.
- Reset mid-operation discards the credit with no refund pulse. This is intended.
- Coin acceptance: a coin is accepted when coin_valid=1, coin_type != 11, mode=1, the state is IDLE or COLLECT, buy=0, cancel=0, and credit+value <= MAX_CREDIT.
  - Credit is updated at the same clock edge.
  - Every other coin_valid pulse is rejected: coin_reject=1 in the following cycle and credit is unchanged.
- Addition uses a 5-bit intermediate; the compare is against MAX_CREDIT. Credit never wraps.
- IDLE:
  - Accepted coin -> COLLECT; credit = value; timer = 0.
  - buy and cancel are ignored.
- COLLECT, priority from top:
  - mode=0 -> REFUND.
  - cancel -> REFUND.
  - buy -> OFFER (credit > 0 always holds in COLLECT).
  - Timer reaches TIMEOUT_CYCLES-1 -> REFUND.
  - Accepted coin -> credit += value; timer reloads to 0.
  - Otherwise the timer increments.
  - A coin arriving in the same cycle as buy or cancel is rejected.
- OFFER:
  - offer_valid=1; offer_money=credit, stable until the handshake completes.
  - Coins are rejected. cancel, mode and the timer are ignored, because the handshake must complete.
  - offer_valid & offer_ready at an edge -> IDLE; credit=0; offer_valid=0 in the next cycle.
  - offer_ready in the cycle the state enters OFFER has no effect; a handshake is recognised only while offer_valid=1.
- REFUND: exactly one cycle.
  - refund_valid=1 and refund_amount=credit.
  - Next state IDLE with credit=0. Coins are rejected.
- Latency:
  - coin to credit: 1 edge.
  - buy to offer_valid: 1 cycle.
  - cancel to refund_valid: 1 cycle.
  - timeout: refund_valid asserts TIMEOUT_CYCLES cycles after the last accepted coin.

Decomposition:
- Shared package vend_pkg holds:
  - State encoding: IDLE, COLLECT, OFFER, REFUND.
  - coin_type codes and coin values: 1, 2, 5.
  - MAX_CREDIT default and the 4-bit money width.
- One sub-module: inactivity_timer, with inputs clear, enable and TIMEOUT_CYCLES, and a one-cycle expired output.
- The FSM and credit datapath live in the top module.

Test Plan:
- Coins 5, 2, 1, then buy; offer_ready held at 1 -> credit goes 5, 7, 8; offer_valid=1 with offer_money=8 for one cycle; then IDLE with credit=0.
- Credit 12, insert 5 -> coin_reject pulse; credit stays 12. Then insert 2 -> credit 14.
- Credit 3, then no activity with TIMEOUT_CYCLES=8 -> refund_valid=1 and refund_amount=3 exactly 8 cycles after the last coin; credit=0 afterwards.
- Credit 6, coin_valid and cancel in the same cycle -> coin_reject=1, refund_amount=6.
- Offer of 4 with offer_ready=0 for 5 cycles, a coin and cancel injected meanwhile, then offer_ready=1 -> offer_money holds 4 throughout, the coin is rejected, no refund is issued, and the handshake completes.
- Credit 9 in COLLECT, rst_n pulsed low mid-cycle -> all outputs 0 immediately, state IDLE, no refund pulse. Also: coin while mode=0 -> coin_reject.
